instr_fetch: RTL and testbench

//  Instruction fetch unit: owns the PC and reads 32-bit words from a word-addressed instruction memory
//  (req/gnt/rvalid protocol, at most one request in flight). Delivers instruction + pc to the decode

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/gnt/rvalid,
// hands it to decode over valid/ready and follows branch/jump redirects from execute.
`timescale 1ns/1ps
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [31:0]       pc,
  output logic              fetch_err,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a word moves to decode on a cycle with instr_valid && instr_ready; while
  // instr_valid && !instr_ready, instruction and pc hold. A memory request is taken on
  // imem_req && imem_gnt and answered by exactly one later imem_rvalid pulse.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_KILL = 3'd3,
    S_HOLD = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_q;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_instruction;
  logic [31:0] r_pc;
  logic        r_instr_valid;
  logic        r_fetch_err;

  state_t      w_state_nxt;
  logic [31:0] w_pc_q_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_valid_nxt;
  logic        w_err_nxt;
  logic        w_redir;
  logic        w_redir_bad;

  assign w_redir     = redirect_valid && (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_redir_bad = w_redir && (redirect_pc[1:0] != 2'b00);

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc_q[ADDR_W+1:2];
  assign instr_valid = r_instr_valid;
  assign instruction = r_instruction;
  assign pc          = r_pc;
  assign fetch_err   = r_fetch_err;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc_q        <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_instruction <= NOP_INSTR;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_q        <= w_pc_q_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_instruction <= w_instr_nxt;
      r_pc          <= w_pc_nxt;
      r_instr_valid <= w_valid_nxt;
      r_fetch_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_q_nxt     = r_pc_q;
    w_fetch_pc_nxt = r_fetch_pc;
    w_instr_nxt    = r_instruction;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_instr_valid;
    w_err_nxt      = r_fetch_err;
    if (w_redir_bad) begin
      w_state_nxt = S_ERR;
      w_err_nxt   = 1'b1;
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
    end else if (w_redir) begin
      // A granted-but-unanswered request is stale; KILL swallows its response.
      w_pc_q_nxt  = redirect_pc;
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
      case (r_state)
        S_REQ:   w_state_nxt = imem_gnt ? S_KILL : S_REQ;
        S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
        S_KILL:  w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
        S_HOLD:  w_state_nxt = S_REQ;
        default: w_state_nxt = r_state;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            w_fetch_pc_nxt = r_pc_q;
            w_pc_q_nxt     = r_pc_q + 32'd4;
            w_state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_instr_nxt = imem_rdata;
            w_pc_nxt    = r_fetch_pc;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_KILL: begin
          if (imem_rvalid) w_state_nxt = S_REQ;
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
            w_state_nxt = S_REQ;
          end
        end
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder, directed scenarios, a randomized phase and a
// per-cycle compare process that follows the PC stream at transaction level.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 14;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic [31:0]       pc;
  logic              fetch_err;
  logic [2:0]        dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .pc(pc), .fetch_err(fetch_err),
    .o_dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 14'd0) return 32'h00A0_0093;
    if (a == 14'd1) return 32'h0020_81B3;
    return {2'b10, a, ~a, 2'b11};
  endfunction

  // Memory responder: grants with gnt_pct probability, answers after dly_min..dly_max cycles.
  int                gnt_pct = 100;
  int                dly_min = 1;
  int                dly_max = 1;
  bit                pend = 0;
  int                cnt = 0;
  logic [ADDR_W-1:0] paddr = '0;
  bit                req_prev = 0;
  logic [ADDR_W-1:0] addr_prev = '0;

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (req_prev && imem_gnt) begin
        pend  = 1;
        paddr = addr_prev;
        cnt   = $urandom_range(dly_max, dly_min);
      end
      if (!rst) begin
        if (pend) begin imem_rvalid = 1'b1; imem_rdata = mem_word(paddr); pend = 0; end
        imem_gnt = 1'b0;
        req_prev = 0;
      end else begin
        if (pend) begin
          if (cnt <= 1) begin imem_rvalid = 1'b1; imem_rdata = mem_word(paddr); pend = 0; end
          else cnt--;
        end
        imem_gnt  = ($urandom_range(99, 0) < gnt_pct);
        req_prev  = imem_req;
        addr_prev = imem_addr;
      end
    end
  end

  // Compare process + reference model (expected PC stream, sticky error, outstanding flag).
  logic [31:0]       exp_pc = RESET_PC;
  bit                m_err = 0;
  bit                m_out = 0;
  int                since = 0;
  bit                prev_hold = 0;
  bit                prev_drop = 0;
  logic [31:0]       prev_pc = '0;
  logic [31:0]       prev_instr = '0;
  int                cyc = 0;
  int                n_deliv = 0;
  int                last_cyc = 0;
  int                deliv_gap = 0;
  logic [31:0]       last_pc = '0;
  logic [31:0]       last_instr = '0;
  int                n_gnt = 0;
  logic [ADDR_W-1:0] last_gnt_addr = '0;

  initial begin
    forever begin
      bit redir;
      @(negedge clk); #3;
      cyc++;
      if (!rst) begin
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instruction, NOP);
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_err", fetch_err, 1'b0);
        exp_pc = RESET_PC; m_err = 0; m_out = 0; since = 0; prev_hold = 0; prev_drop = 0;
      end else begin
        check_eq("fetch_err", fetch_err, m_err);
        if (m_err) begin
          check_eq("err_req", imem_req, 1'b0);
          check_eq("err_valid", instr_valid, 1'b0);
        end
        if (!instr_valid) check_eq("idle_nop", instruction, NOP);
        if (imem_req) check_eq("one_outstanding", m_out, 1'b0);
        if (prev_hold) begin
          check_eq("hold_valid", instr_valid, 1'b1);
          check_eq("hold_pc", pc, prev_pc);
          check_eq("hold_instr", instruction, prev_instr);
        end
        if (prev_drop) check_eq("drop_valid", instr_valid, 1'b0);
        redir = redirect_valid && (since >= 1) && !m_err;
        if (imem_rvalid) m_out = 0;
        if (imem_req) begin
          check_eq("req_addr", imem_addr, exp_pc[ADDR_W+1:2]);
          if (imem_gnt) begin n_gnt++; last_gnt_addr = imem_addr; m_out = 1; end
        end
        prev_hold = 0; prev_drop = 0;
        if (instr_valid && instr_ready) begin
          check_eq("deliv_pc", pc, exp_pc);
          check_eq("deliv_instr", instruction, mem_word(pc[ADDR_W+1:2]));
          n_deliv++; last_pc = pc; last_instr = instruction;
          deliv_gap = cyc - last_cyc; last_cyc = cyc;
          exp_pc = exp_pc + 32'd4;
          prev_drop = 1;
        end else if (instr_valid && !redir) begin
          prev_hold = 1; prev_pc = pc; prev_instr = instruction;
        end
        if (redir) begin
          prev_drop = 1; prev_hold = 0;
          if (redirect_pc[1:0] != 2'b00) m_err = 1;
          else exp_pc = redirect_pc;
        end
        since++;
      end
    end
  end

  // Driver tasks (all return aligned to a falling edge)
  task automatic wait_deliv(input string name);
    int target;
    int k;
    target = n_deliv + 1; k = 0;
    while (n_deliv < target && k < 60) begin @(negedge clk); k++; end
    check_eq(name, (n_deliv >= target), 1'b1);
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!imem_req && k < 30) begin @(negedge clk); k++; end
    check_eq(name, imem_req, 1'b1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1; redirect_pc = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int k;
    int g0;
    int d0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);

    // Back-to-back fetch with immediate grant and one-cycle response.
    instr_ready = 1'b1; rst = 1'b1;
    wait_deliv("t1_d0");
    check_eq("t1_pc0", last_pc, 32'h0);
    check_eq("t1_instr0", last_instr, 32'h00A0_0093);
    check_eq("t1_gnt_addr0", last_gnt_addr, 14'h0);
    wait_deliv("t1_d1");
    check_eq("t1_pc1", last_pc, 32'h4);
    check_eq("t1_instr1", last_instr, 32'h0020_81B3);
    check_eq("t1_gap1", deliv_gap, 3);
    wait_deliv("t1_d2");
    check_eq("t1_pc2", last_pc, 32'h8);
    check_eq("t1_gap2", deliv_gap, 3);

    // Decode stalls: word at 0xC must sit still for 5 cycles with no new request.
    instr_ready = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_valid", instr_valid, 1'b1);
      check_eq("t2_pc", pc, 32'hC);
      check_eq("t2_instr", instruction, mem_word(14'h3));
      check_eq("t2_req", imem_req, 1'b0);
      @(negedge clk);
    end
    instr_ready = 1'b1;

    // Redirect during WAIT, response two cycles later.
    dly_min = 3; dly_max = 3;
    wait_req("t3_req");
    @(negedge clk);
    pulse_redirect(32'h40);
    g0 = n_gnt; k = 0;
    while (n_gnt == g0 && k < 30) begin @(negedge clk); k++; end
    check_eq("t3_gnt_addr", last_gnt_addr, 14'h10);
    wait_deliv("t3_d");
    check_eq("t3_pc", last_pc, 32'h40);
    check_eq("t3_instr", last_instr, mem_word(14'h10));

    // Redirect coinciding with the grant, then with the response.
    dly_min = 1; dly_max = 1;
    wait_req("t4a_req");
    pulse_redirect(32'h80);
    wait_deliv("t4a_d");
    check_eq("t4a_pc", last_pc, 32'h80);
    wait_req("t4b_req");
    @(negedge clk);
    pulse_redirect(32'h80);
    wait_deliv("t4b_d");
    check_eq("t4b_pc", last_pc, 32'h80);
    check_eq("t4b_instr", last_instr, mem_word(14'h20));

    // Reset while a response is outstanding, then PC wrap at the top of memory.
    dly_min = 2; dly_max = 2;
    wait_req("t6_req");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dly_min = 1; dly_max = 1;
    wait_deliv("t6_d0");
    check_eq("t6_pc0", last_pc, RESET_PC);
    check_eq("t6_instr0", last_instr, 32'h00A0_0093);
    pulse_redirect(32'hFFFF_FFFC);
    wait_deliv("t6_dtop");
    check_eq("t6_pc_top", last_pc, 32'hFFFF_FFFC);
    wait_deliv("t6_dwrap");
    check_eq("t6_pc_wrap", last_pc, 32'h0);

    // Randomized traffic: stalls, slow memory, aligned redirects, occasional reset.
    gnt_pct = 60; dly_min = 1; dly_max = 4;
    d0 = n_deliv;
    for (int c = 0; c < 1500; c++) begin
      if (c % 500 == 250) begin
        rst = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
      instr_ready    = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
    end
    redirect_valid = 1'b0; instr_ready = 1'b1;
    check_eq("rand_progress", (n_deliv - d0 >= 50), 1'b1);

    // Misaligned redirect: sticky error until reset, then restart from RESET_PC.
    gnt_pct = 100; dly_min = 1; dly_max = 1;
    wait_deliv("t5_pre");
    pulse_redirect(32'h42);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_err", fetch_err, 1'b1);
      check_eq("t5_req", imem_req, 1'b0);
      check_eq("t5_valid", instr_valid, 1'b0);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_err_cleared", fetch_err, 1'b0);
    rst = 1'b1;
    wait_deliv("t5_d");
    check_eq("t5_pc", last_pc, RESET_PC);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
